// File: rtl/flow_deproc.sv
// Receive-side decoder for the flow_proc XOR packet encoding.
// Buffers one encoded packet, then replays it decoded, one beat per cycle.
module flow_deproc #(
    parameter int DATA_WIDTH = 8,
    parameter int MAX_LEN    = 16,
    parameter int ADDR_W     = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  data_in_vld,
    input  logic                  sop_in_vld,
    input  logic                  eop_in_vld,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  in_rdy,
    output logic                  data_out_vld,
    output logic                  sop_out_vld,
    output logic                  eop_out_vld,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  drop_err
);

    typedef enum logic [1:0] {IDLE, RECV, SEND} state_t;

    localparam logic [ADDR_W:0] LEN_MAX = (ADDR_W+1)'(MAX_LEN);
    localparam logic [ADDR_W:0] LEN_ONE = (ADDR_W+1)'(1);

    state_t                state, state_n;
    logic [ADDR_W:0]       len, len_n;
    logic [ADDR_W-1:0]     rd, rd_n;
    logic [DATA_WIDTH-1:0] acc, acc_n;
    logic                  skip, skip_n;
    logic                  wr_en;
    logic [ADDR_W-1:0]     wr_addr;
    logic                  vld_n, sop_n, eop_n, drop_n;
    logic [DATA_WIDTH-1:0] data_n;
    logic [ADDR_W:0]       last_idx;
    logic                  last_beat;

    logic [DATA_WIDTH-1:0] mem [MAX_LEN];

    // NOTE: the packet buffer has no reset; every slot is written before it is read.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= data_in;
    end

    assign last_idx  = len - LEN_ONE;
    assign last_beat = ({1'b0, rd} == last_idx);

    // Hold off a new packet until the final decoded beat has left the output register.
    assign in_rdy = (state == IDLE) && !eop_out_vld;

    // NOTE: every output of this block is assigned a default first so no latch is inferred.
    always_comb begin
        state_n = state;
        len_n   = len;
        rd_n    = rd;
        acc_n   = acc;
        skip_n  = skip;
        wr_en   = 1'b0;
        wr_addr = len[ADDR_W-1:0];
        vld_n   = 1'b0;
        sop_n   = 1'b0;
        eop_n   = 1'b0;
        drop_n  = 1'b0;
        data_n  = '0;

        case (state)
            IDLE: begin
                skip_n = 1'b0;
                rd_n   = '0;
                if (data_in_vld && sop_in_vld) begin
                    wr_en   = 1'b1;
                    wr_addr = '0;
                    acc_n   = data_in;
                    len_n   = LEN_ONE;
                    state_n = eop_in_vld ? SEND : RECV;
                end
            end
            RECV: begin
                rd_n = '0;
                if (!data_in_vld) begin
                    drop_n  = 1'b1;
                    state_n = IDLE;
                end else if (sop_in_vld) begin
                    // Restart: the old packet is lost, the new beat becomes beat 0.
                    drop_n  = 1'b1;
                    wr_en   = 1'b1;
                    wr_addr = '0;
                    acc_n   = data_in;
                    len_n   = LEN_ONE;
                    state_n = eop_in_vld ? SEND : RECV;
                end else if (len == LEN_MAX) begin
                    drop_n  = 1'b1;
                    state_n = IDLE;
                end else begin
                    wr_en = 1'b1;
                    acc_n = acc ^ data_in;
                    len_n = len + LEN_ONE;
                    if (eop_in_vld) state_n = SEND;
                end
            end
            SEND: begin
                vld_n  = 1'b1;
                data_n = acc;
                sop_n  = (rd == '0);
                eop_n  = last_beat;
                acc_n  = acc ^ mem[rd];
                rd_n   = rd + 1'b1;
                if (last_beat) state_n = IDLE;
                // An intruding packet is reported once and swallowed through its eop.
                if (data_in_vld) begin
                    if (!skip) drop_n = 1'b1;
                    skip_n = !eop_in_vld;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            len          <= '0;
            rd           <= '0;
            acc          <= '0;
            skip         <= 1'b0;
            data_out_vld <= 1'b0;
            sop_out_vld  <= 1'b0;
            eop_out_vld  <= 1'b0;
            data_out     <= '0;
            drop_err     <= 1'b0;
        end else begin
            state        <= state_n;
            len          <= len_n;
            rd           <= rd_n;
            acc          <= acc_n;
            skip         <= skip_n;
            data_out_vld <= vld_n;
            sop_out_vld  <= sop_n;
            eop_out_vld  <= eop_n;
            data_out     <= data_n;
            drop_err     <= drop_n;
        end
    end

endmodule
